// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit read/write registers.
// AW and W may arrive in either order; each is buffered until its partner
// shows up, and the write commits on the edge where both are available.
// One write and one read may be outstanding at a time. All register
// contents and a per-register write pulse are presented to local logic.
module axi4_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // Write address channel
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  // Write data channel
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [3:0]                     S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  // Write response channel
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  // Read address channel
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  // Read data channel
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  // Local side
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register bank
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Write-side state
  logic                  aw_full_q;
  logic [IDX_W-1:0]      awidx_q;
  logic                  w_full_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;

  // Read-side state
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  // Combinational helpers
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [IDX_W-1:0]      widx;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [3:0]            wstrb_c;
  logic                  w_in_range;
  logic [IDX_W-1:0]      ridx;
  logic                  r_in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  // Byte-offset address bits carry no meaning for word registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies come straight from state so they read 1 while in reset.
  assign S_AXI_AWREADY = !aw_full_q && !bvalid_q;
  assign S_AXI_WREADY  = !w_full_q  && !bvalid_q;
  assign S_AXI_ARREADY = !rvalid_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Commit once address and data are each either buffered or handshaking now.
  always_comb begin
    commit     = (aw_full_q || aw_hs) && (w_full_q || w_hs);
    widx       = aw_full_q ? awidx_q : S_AXI_AWADDR[ADDR_WIDTH-1:2];
    wdata_c    = w_full_q  ? wdata_q : S_AXI_WDATA;
    wstrb_c    = w_full_q  ? wstrb_q : S_AXI_WSTRB;
    w_in_range = (64'(widx) < 64'(NUM_REGS));
  end

  // Read decode and word select from the current register contents.
  always_comb begin
    ridx       = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    r_in_range = (64'(ridx) < 64'(NUM_REGS));
    rd_word    = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (ridx == IDX_W'(k)) begin
        rd_word = regs_q[k];
      end
    end
  end

  // Buffer an AW or W that arrives ahead of its partner; commit empties both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      awidx_q   <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (commit) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        awidx_q   <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
    end
  end

  // Byte-masked register update on an in-range commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (commit && w_in_range) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (widx == IDX_W'(k)) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb_c[b]) begin
              regs_q[k][8*b +: 8] <= wdata_c[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // One-cycle write pulse for the committed register, even with WSTRB=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (commit && w_in_range) begin
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
          if (widx == IDX_W'(k)) begin
            wr_pulse_q[k] <= 1'b1;
          end
        end
      end
    end
  end

  // Write response: raised on commit, held until BREADY is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read response: captures the pre-edge register value, held until RREADY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= r_in_range ? rd_word : '0;
      rresp_q  <= r_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  // Flatten the register bank for local logic.
  always_comb begin
    reg_out = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      reg_out[DATA_WIDTH*k +: DATA_WIDTH] = regs_q[k];
    end
  end

  assign reg_wr_pulse = wr_pulse_q;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs with the default 16 x 32-bit bank.
module tb_axi4_lite_slave_regs;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [3:0]      wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]   reg_wr_pulse;

  int n_cmp;
  int n_err;

  axi4_lite_slave_regs #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] regv(input int k);
    return reg_out[32*k +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0;
    araddr = '0; arvalid = 1'b0;
    rready = 1'b0;

    // Reset state
    step(); step();
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_wready",  64'(wready),  64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_bvalid",  64'(bvalid),  64'd0);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_pulse",   64'(reg_wr_pulse), 64'd0);
    chk("rst_regout_or", 64'(|reg_out), 64'd0);
    rst_n = 1'b1;
    step();

    // Simultaneous AW/W to reg2
    awaddr = 32'h08; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b1;
    step();
    chk("t1_bvalid", 64'(bvalid), 64'd1);
    chk("t1_bresp",  64'(bresp),  64'd0);
    chk("t1_pulse",  64'(reg_wr_pulse), 64'h0004);
    chk("t1_reg2",   64'(regv(2)), 64'hDEADBEEF);
    chk("t1_awready_busy", 64'(awready), 64'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    chk("t1_bvalid_drop", 64'(bvalid), 64'd0);
    chk("t1_pulse_drop",  64'(reg_wr_pulse), 64'h0000);

    // W first, AW three cycles later
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
    step();
    chk("t2_wready_low", 64'(wready), 64'd0);
    chk("t2_awready",    64'(awready), 64'd1);
    chk("t2_no_bvalid",  64'(bvalid), 64'd0);
    wvalid = 1'b0;
    step(); step();
    chk("t2_wready_held", 64'(wready), 64'd0);
    chk("t2_reg3_unchanged", 64'(regv(3)), 64'h0);
    awaddr = 32'h0C; awvalid = 1'b1;
    step();
    chk("t2_bvalid", 64'(bvalid), 64'd1);
    chk("t2_reg3",   64'(regv(3)), 64'h11223344);
    chk("t2_pulse",  64'(reg_wr_pulse), 64'h0008);
    awvalid = 1'b0;
    step();
    chk("t2_bvalid_drop", 64'(bvalid), 64'd0);
    chk("t2_wready_back", 64'(wready), 64'd1);

    // Byte strobe on reg2, then read at unaligned 0x0A
    awaddr = 32'h08; awvalid = 1'b1;
    wdata = 32'h000000AA; wstrb = 4'b0001; wvalid = 1'b1;
    step();
    chk("t3_reg2", 64'(regv(2)), 64'hDEADBEAA);
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    araddr = 32'h0A; arvalid = 1'b1; rready = 1'b0;
    step();
    chk("t3_rvalid", 64'(rvalid), 64'd1);
    chk("t3_rdata",  64'(rdata),  64'hDEADBEAA);
    chk("t3_rresp",  64'(rresp),  64'd0);
    chk("t3_arready_busy", 64'(arready), 64'd0);
    arvalid = 1'b0; rready = 1'b1;
    step();
    chk("t3_rvalid_drop", 64'(rvalid), 64'd0);
    chk("t3_arready_back", 64'(arready), 64'd1);

    // Out-of-range write and read at 0x40
    awaddr = 32'h40; awvalid = 1'b1;
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    step();
    chk("t4_bvalid", 64'(bvalid), 64'd1);
    chk("t4_bresp",  64'(bresp),  64'd2);
    chk("t4_pulse",  64'(reg_wr_pulse), 64'h0);
    chk("t4_reg0",   64'(regv(0)), 64'h0);
    chk("t4_reg2",   64'(regv(2)), 64'hDEADBEAA);
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    araddr = 32'h40; arvalid = 1'b1;
    step();
    chk("t4_rvalid", 64'(rvalid), 64'd1);
    chk("t4_rdata",  64'(rdata),  64'h0);
    chk("t4_rresp",  64'(rresp),  64'd2);
    arvalid = 1'b0;
    step();

    // BREADY held low: response stable, no new AW/W accepted
    bready = 1'b0;
    awaddr = 32'h04; awvalid = 1'b1;
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    step();
    chk("t5_bvalid", 64'(bvalid), 64'd1);
    chk("t5_reg1",   64'(regv(1)), 64'hCAFEF00D);
    awaddr = 32'h10; wdata = 32'h55AA55AA;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_bvalid",  64'(bvalid),  64'd1);
      chk("t5_hold_bresp",   64'(bresp),   64'd0);
      chk("t5_hold_awready", 64'(awready), 64'd0);
      chk("t5_hold_wready",  64'(wready),  64'd0);
    end
    // BREADY and a pending AW together: AW not taken that edge
    bready = 1'b1;
    step();
    chk("t5_bvalid_drop", 64'(bvalid), 64'd0);
    chk("t5_reg4_untouched", 64'(regv(4)), 64'h0);
    chk("t5_awready_back", 64'(awready), 64'd1);
    step();
    chk("t5_second_bvalid", 64'(bvalid), 64'd1);
    chk("t5_reg4", 64'(regv(4)), 64'h55AA55AA);
    awvalid = 1'b0; wvalid = 1'b0;
    step();

    // RREADY held low: read data stable, ARREADY low; then 2-cycle throughput
    araddr = 32'h04; arvalid = 1'b1; rready = 1'b0;
    step();
    chk("t6_rdata", 64'(rdata), 64'hCAFEF00D);
    araddr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_hold_rvalid",  64'(rvalid),  64'd1);
      chk("t6_hold_rdata",   64'(rdata),   64'hCAFEF00D);
      chk("t6_hold_rresp",   64'(rresp),   64'd0);
      chk("t6_hold_arready", 64'(arready), 64'd0);
    end
    rready = 1'b1;
    step();
    chk("t6_rvalid_drop", 64'(rvalid), 64'd0);
    step();
    chk("t6_next_rvalid", 64'(rvalid), 64'd1);
    chk("t6_next_rdata",  64'(rdata),  64'h55AA55AA);
    arvalid = 1'b0;
    step();

    // Read and write to the same register on one edge: read sees old value
    rready = 1'b0;
    awaddr = 32'h10; awvalid = 1'b1;
    wdata = 32'h01020304; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h10; arvalid = 1'b1;
    step();
    chk("t7_rdata_old", 64'(rdata), 64'h55AA55AA);
    chk("t7_reg4_new",  64'(regv(4)), 64'h01020304);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b1;
    step();

    // WSTRB=0 in range: OKAY, pulse, no data change
    awaddr = 32'h04; awvalid = 1'b1;
    wdata = 32'hFFFFFFFF; wstrb = 4'b0000; wvalid = 1'b1;
    step();
    chk("t8_bresp", 64'(bresp), 64'd0);
    chk("t8_pulse", 64'(reg_wr_pulse), 64'h0002);
    chk("t8_reg1",  64'(regv(1)), 64'hCAFEF00D);
    awvalid = 1'b0; wvalid = 1'b0;
    step();

    // Reset with a buffered AW and a pending read response
    awaddr = 32'h00; awvalid = 1'b1;
    step();
    chk("t9_aw_buffered", 64'(awready), 64'd0);
    awvalid = 1'b0;
    araddr = 32'h04; arvalid = 1'b1; rready = 1'b0;
    step();
    chk("t9_rvalid_pre", 64'(rvalid), 64'd1);
    arvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t9_rst_rvalid",  64'(rvalid),  64'd0);
    chk("t9_rst_rdata",   64'(rdata),   64'd0);
    chk("t9_rst_awready", 64'(awready), 64'd1);
    chk("t9_rst_arready", 64'(arready), 64'd1);
    chk("t9_rst_reg1",    64'(regv(1)), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    bready = 1'b1;
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    step();
    chk("t9_no_stale_commit", 64'(bvalid), 64'd0);
    chk("t9_w_buffered",      64'(wready), 64'd0);
    wvalid = 1'b0;
    awaddr = 32'h00; awvalid = 1'b1;
    step();
    chk("t9_bvalid", 64'(bvalid), 64'd1);
    chk("t9_reg0",   64'(regv(0)), 64'hA5A5A5A5);
    awvalid = 1'b0;
    step();
    chk("t9_bvalid_drop", 64'(bvalid), 64'd0);
    step();
    chk("t9_single_bvalid", 64'(bvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
- AXI4-Lite responder (slave) exposing a bank of NUM_REGS 32-bit read/write registers to a single AXI4-Lite master.
- Sits at the far end of the team's single-beat AXI4-Lite master.
- Handles independent AW/W arrival, byte strobes, SLVERR on out-of-range addresses, and one outstanding read and one outstanding write.
- Presents all register contents and per-register write pulses to local logic.

Parameters:
- ADDR_WIDTH, 32, width of AWADDR/ARADDR.
- DATA_WIDTH, 32, data width; only 32 is supported, so WSTRB is 4 bits.
- NUM_REGS, 16, number of registers, 1..2^(ADDR_WIDTH-2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- S_AXI_AWADDR  input  ADDR_WIDTH  write address
- S_AXI_AWVALID  input  1  write address valid
- S_AXI_AWREADY  output  1  write address ready
- S_AXI_WDATA  input  DATA_WIDTH  write data
- S_AXI_WSTRB  input  4  byte enables; bit i covers WDATA[8i+7:8i]
- S_AXI_WVALID  input  1  write data valid
- S_AXI_WREADY  output  1  write data ready
- S_AXI_BRESP  output  2  write response, 00 OKAY / 10 SLVERR
- S_AXI_BVALID  output  1  write response valid
- S_AXI_BREADY  input  1  write response ready
- S_AXI_ARADDR  input  ADDR_WIDTH  read address
- S_AXI_ARVALID  input  1  read address valid
- S_AXI_ARREADY  output  1  read address ready
- S_AXI_RDATA  output  DATA_WIDTH  read data
- S_AXI_RRESP  output  2  read response, 00 OKAY / 10 SLVERR
- S_AXI_RVALID  output  1  read data valid
- S_AXI_RREADY  input  1  read data ready
- reg_out  output  NUM_REGS*DATA_WIDTH  flat register contents; reg k at [32k+31:32k]
- reg_wr_pulse  output  NUM_REGS  one-cycle pulse per register on a committed write

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers 0.
  - aw_full, w_full, BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0; reg_wr_pulse = 0.
  - Readies are derived from state, so AWREADY/WREADY/ARREADY read 1 while in reset.
- Reset mid-transaction aborts it: no response is issued and buffered AW/W is discarded.
- Decode: index = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored. Index >= NUM_REGS is out of range.
- Write path:
  - AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID.
  - AW handshake with no matching W: latch address, set aw_full. W handshake with no matching AW: latch data and strobe, set w_full.
  - Commit edge: the edge where an address (buffered or handshaking) and data (buffered or handshaking) are both available.
  - On the commit edge, in range: update only the bytes with WSTRB=1; BRESP=00; reg_wr_pulse[index]=1 for exactly the next cycle.
  - On the commit edge, out of range: no register change; BRESP=10; no pulse.
  - On the commit edge, always: BVALID=1 and aw_full, w_full cleared.
  - WSTRB=0000 in range: OKAY, no bytes change, pulse still asserted.
  - Latency: AW and W handshake in the same cycle N -> register updated and BVALID high in cycle N+1.
  - BVALID and BRESP hold until BREADY is seen high with BVALID; BVALID clears on that edge.
  - AWREADY/WREADY are low while BVALID=1, so at most one write is outstanding.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake in cycle N: RVALID=1 in N+1. In range, RDATA = register value sampled in cycle N, RRESP=00. Out of range, RDATA=0, RRESP=10.
  - RVALID, RDATA and RRESP hold until RREADY is seen high; the next AR is accepted the cycle after RVALID clears.
  - Back-to-back read throughput is one per 2 cycles.
- Simultaneous events:
  - Read and write channels are fully independent.
  - A read handshaking in the same cycle as a write commit to the same register returns the pre-write value.
  - BREADY and a new AW in the same cycle: AW is not accepted that cycle because AWREADY=0.
- reg_out is driven directly from the registers and reflects a write in the cycle after the commit edge.

Test Plan:
- Reset, then AW=0x08 and W=0xDEADBEEF with WSTRB=F in one cycle, BREADY=1 -> next cycle BVALID=1, BRESP=00, reg_wr_pulse=0x0004, reg_out reg2=0xDEADBEEF; BVALID drops the cycle after.
- W=0x11223344 first, AW=0x0C three cycles later -> WREADY low after the W handshake. One cycle after AW: reg3=0x11223344, BVALID=1.
- reg2=0xDEADBEEF, write 0x000000AA with WSTRB=0001 to 0x08 -> reg2=0xDEADBEAA. Read 0x0A -> RDATA=0xDEADBEAA, RRESP=00.
- Write to 0x40 with NUM_REGS=16 -> BRESP=10, no register change, no pulse. Read 0x40 -> RDATA=0, RRESP=10.
- Hold BREADY=0 for 5 cycles after a write -> BVALID/BRESP stable and AWREADY=WREADY=0 throughout. Hold RREADY=0 after a read -> RVALID/RDATA stable and ARREADY=0.
- Assert rst_n=0 with aw_full=1 and RVALID=1 -> outputs immediately at reset values. After release, a fresh write to 0x00 completes normally with a single BVALID.
